sd_cmd_resp_rx: RTL and testbench

- Receives a 48-bit SD-card command-line response frame (R1/R1b/R3/R6/R7) bit-serially from the CMD pin.
- Checks framing and recomputes CRC7 (x^7 + x^3 + 1) over the first 40 bits.
- Presents the command index and 32-bit argument/status to the SD host controller.
- It is the receive counterpart of the host command transmitter, which generates CRC7 over the same 40-bit span.

---
 rtl/sd_pkg.sv | 21 ++
 rtl/sd_crc7.sv | 21 ++
 rtl/sd_cmd_resp_rx.sv | 118 +++++++++++
 tb/tb_sd_cmd_resp_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD command-line constants, state encoding and CRC7 step
package sd_pkg;

    localparam int SD_FRAME_LEN = 48;
    localparam int SD_CRC_BITS  = 40;
    localparam logic [6:0] SD_CRC7_POLY = 7'h09;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_RECV       = 2'd2
    } resp_state_e;

    // One serial step of x^7 + x^3 + 1, MSB-first.
    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 register with synchronous clear and bit enable
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            crc <= 7'h00;
        end else if (en) begin
            crc <= crc7_next(crc, bit_in);
        end
    end

endmodule

// File: rtl/sd_cmd_resp_rx.sv
// rtl/sd_cmd_resp_rx.sv - bit-serial 48-bit SD response receiver with framing and CRC7 check
module sd_cmd_resp_rx
    import sd_pkg::*;
#(
    parameter int NCR_MAX   = 64,
    parameter int CHECK_DIR = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_en,
    input  logic        cmd_in,
    input  logic        start,
    input  logic        skip_crc,
    output logic        busy,
    output logic        done,
    output logic [5:0]  resp_index,
    output logic [31:0] resp_arg,
    output logic        crc_ok,
    output logic        frame_err,
    output logic        timeout
);

    localparam int WCNT_W = $clog2(NCR_MAX + 1);

    localparam logic [1:0] S_IDLE       = ST_IDLE;
    localparam logic [1:0] S_WAIT_START = ST_WAIT_START;
    localparam logic [1:0] S_RECV       = ST_RECV;

    logic [1:0]        state;
    logic [WCNT_W-1:0] wait_cnt;
    logic [5:0]        bit_cnt;
    logic [46:0]       shreg;
    logic              skip_q;
    logic [6:0]        crc;
    logic [47:0]       full;
    logic              crc_clear;
    logic              crc_en;

    // Frame as it stands once the current bit is appended; only meaningful on the last bit.
    assign full = {shreg, cmd_in};
    assign busy = (state != S_IDLE);

    assign crc_clear = (state == S_IDLE) && start;
    assign crc_en    = sample_en &&
                       (((state == S_WAIT_START) && !cmd_in) ||
                        ((state == S_RECV) && (bit_cnt < 6'(SD_CRC_BITS))));

    sd_crc7 u_crc7 (
        .clk    (clk),
        .rst    (rst),
        .clear  (crc_clear),
        .en     (crc_en),
        .bit_in (cmd_in),
        .crc    (crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            skip_q     <= 1'b0;
            done       <= 1'b0;
            resp_index <= '0;
            resp_arg   <= '0;
            crc_ok     <= 1'b0;
            frame_err  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        skip_q    <= skip_crc;
                        crc_ok    <= 1'b0;
                        frame_err <= 1'b0;
                        timeout   <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    if (sample_en) begin
                        if (!cmd_in) begin
                            shreg   <= {shreg[45:0], cmd_in};
                            bit_cnt <= 6'd1;
                            state   <= S_RECV;
                        end else if (wait_cnt == WCNT_W'(NCR_MAX - 1)) begin
                            timeout <= 1'b1;
                            done    <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (sample_en) begin
                        shreg   <= {shreg[45:0], cmd_in};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 6'(SD_FRAME_LEN - 1)) begin
                            resp_index <= full[45:40];
                            resp_arg   <= full[39:8];
                            crc_ok     <= skip_q || (crc == full[7:1]);
                            frame_err  <= full[47] || !full[0] ||
                                          ((CHECK_DIR != 0) && full[46]);
                            done       <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// tb/tb_sd_cmd_resp_rx.sv - directed-vector bench for sd_cmd_resp_rx
module tb_sd_cmd_resp_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sample_en = 1'b0;
    logic cmd_in = 1'b1;
    logic start = 1'b0;
    logic skip_crc = 1'b0;

    logic        busy0, done0, ok0, fe0, to0;
    logic [5:0]  idx0;
    logic [31:0] arg0;
    logic        busy1, done1, ok1, fe1, to1;
    logic [5:0]  idx1;
    logic [31:0] arg1;
    logic [40:0] res0, res1;

    int vec = 0;
    int bad = 0;
    int done_cnt = 0;

    assign res0 = {idx0, arg0, ok0, fe0, to0};
    assign res1 = {idx1, arg1, ok1, fe1, to1};

    always #5 clk = ~clk;

    always @(negedge clk) if (done0) done_cnt++;

    sd_cmd_resp_rx #(.NCR_MAX(64), .CHECK_DIR(0)) dut0 (
        .clk(clk), .rst(rst), .sample_en(sample_en), .cmd_in(cmd_in),
        .start(start), .skip_crc(skip_crc), .busy(busy0), .done(done0),
        .resp_index(idx0), .resp_arg(arg0), .crc_ok(ok0),
        .frame_err(fe0), .timeout(to0)
    );

    sd_cmd_resp_rx #(.NCR_MAX(64), .CHECK_DIR(1)) dut1 (
        .clk(clk), .rst(rst), .sample_en(sample_en), .cmd_in(cmd_in),
        .start(start), .skip_crc(skip_crc), .busy(busy1), .done(done1),
        .resp_index(idx1), .resp_arg(arg1), .crc_ok(ok1),
        .frame_err(fe1), .timeout(to1)
    );

    function automatic logic [40:0] pack(input logic [5:0] i, input logic [31:0] a,
                                         input logic ok, input logic fe, input logic to);
        return {i, a, ok, fe, to};
    endfunction

    // One strobe followed by one idle cycle; returns at the negedge after the strobe edge.
    task automatic strobe(input logic b);
        @(negedge clk);
        sample_en = 1'b1;
        cmd_in    = b;
        @(negedge clk);
        sample_en = 1'b0;
        cmd_in    = 1'b1;
    endtask

    task automatic idle_strobes(input int n);
        for (int i = 0; i < n; i++) strobe(1'b1);
    endtask

    task automatic send_bits(input logic [47:0] f, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) strobe(f[i]);
    endtask

    task automatic arm(input logic skip);
        @(negedge clk);
        start    = 1'b1;
        skip_crc = skip;
        @(negedge clk);
        start    = 1'b0;
        skip_crc = 1'b0;
    endtask

    task automatic run_frame(input string nm, input logic [47:0] f, input logic skip,
                             input int idle, input logic [40:0] e0, input logic [40:0] e1);
        arm(skip);
        vec++;
        if ({busy0, busy1, ok0, fe0, to0} !== 5'b11000) begin
            bad++;
            $display("FAIL %s arm: busy/ok/fe/to got %b expected 11000", nm, {busy0, busy1, ok0, fe0, to0});
        end
        idle_strobes(idle);
        send_bits(f, 47, 1);
        vec++;
        if ({done0, busy0} !== 2'b01) begin
            bad++;
            $display("FAIL %s pre_end: done/busy got %b expected 01", nm, {done0, busy0});
        end
        strobe(f[0]);
        vec++;
        if ({done0, done1, busy0, busy1} !== 4'b1100) begin
            bad++;
            $display("FAIL %s done_latency: done/busy got %b expected 1100", nm, {done0, done1, busy0, busy1});
        end
        vec++;
        if (res0 !== e0) begin
            bad++;
            $display("FAIL %s result_dir0: got %h expected %h", nm, res0, e0);
        end
        vec++;
        if (res1 !== e1) begin
            bad++;
            $display("FAIL %s result_dir1: got %h expected %h", nm, res1, e1);
        end
        @(negedge clk);
        vec++;
        if ({done0, done1} !== 2'b00) begin
            bad++;
            $display("FAIL %s done_width: got %b expected 00", nm, {done0, done1});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vec++;
        if ({busy0, done0, res0, busy1, done1, res1} !== '0) begin
            bad++;
            $display("FAIL reset: got %h/%h busy %b%b done %b%b expected all zero",
                     res0, res1, busy0, busy1, done0, done1);
        end
        rst = 1'b0;
    endtask

    task automatic test_frames();
        run_frame("cmd0", 48'h40_00_00_00_00_95, 1'b0, 3,
                  pack(6'h00, 32'h0, 1, 0, 0), pack(6'h00, 32'h0, 1, 1, 0));
        run_frame("cmd8", 48'h48_00_00_01_AA_87, 1'b0, 2,
                  pack(6'h08, 32'h1AA, 1, 0, 0), pack(6'h08, 32'h1AA, 1, 1, 0));
        run_frame("crc_bad", 48'h51_00_00_10_00_55, 1'b0, 1,
                  pack(6'h11, 32'h1000, 0, 0, 0), pack(6'h11, 32'h1000, 0, 1, 0));
        run_frame("end_bad", 48'h51_00_00_00_00_54, 1'b0, 0,
                  pack(6'h11, 32'h0, 1, 1, 0), pack(6'h11, 32'h0, 1, 1, 0));
        run_frame("r3_skip", 48'h3F_80_FF_80_00_FF, 1'b1, 2,
                  pack(6'h3F, 32'h80FF8000, 1, 0, 0), pack(6'h3F, 32'h80FF8000, 1, 0, 0));
    endtask

    task automatic test_timeout();
        arm(1'b0);
        idle_strobes(63);
        vec++;
        if ({done0, busy0, to0} !== 3'b010) begin
            bad++;
            $display("FAIL timeout_63: done/busy/to got %b expected 010", {done0, busy0, to0});
        end
        strobe(1'b1);
        vec++;
        if ({done0, busy0, ok0, fe0, to0, to1} !== 6'b100011) begin
            bad++;
            $display("FAIL timeout_64: done/busy/ok/fe/to got %b expected 100011",
                     {done0, busy0, ok0, fe0, to0, to1});
        end
        run_frame("start_on_64", 48'h48_00_00_01_AA_87, 1'b0, 63,
                  pack(6'h08, 32'h1AA, 1, 0, 0), pack(6'h08, 32'h1AA, 1, 1, 0));
    endtask

    task automatic test_abort();
        int c;
        arm(1'b0);
        idle_strobes(2);
        c = done_cnt;
        send_bits(48'h51_00_00_00_00_55, 47, 20);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vec++;
        if ({busy0, done0, res0} !== '0) begin
            bad++;
            $display("FAIL abort_state: busy %b done %b res %h expected all zero", busy0, done0, res0);
        end
        send_bits(48'h51_00_00_00_00_55, 19, 0);
        vec++;
        if (done_cnt !== c || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: done pulses %0d busy %b expected %0d 0", done_cnt - c, busy0, 0);
        end
        run_frame("after_abort", 48'h51_00_00_00_00_55, 1'b0, 1,
                  pack(6'h11, 32'h0, 1, 0, 0), pack(6'h11, 32'h0, 1, 1, 0));
    endtask

    task automatic test_start_ignored();
        logic [47:0] f;
        f = 48'h51_00_00_10_00_55;
        arm(1'b0);
        strobe(1'b1);
        send_bits(f, 47, 21);
        @(negedge clk);
        start    = 1'b1;
        skip_crc = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        skip_crc = 1'b0;
        send_bits(f, 20, 0);
        vec++;
        if ({done0, res0} !== {1'b1, pack(6'h11, 32'h1000, 0, 0, 0)}) begin
            bad++;
            $display("FAIL start_ignored: done %b res %h expected 1 %h",
                     done0, res0, pack(6'h11, 32'h1000, 0, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] f;
        f = 48'h40_00_00_00_00_95;
        arm(1'b0);
        send_bits(f, 47, 1);
        @(negedge clk);
        sample_en = 1'b1;
        cmd_in    = f[0];
        @(negedge clk);
        sample_en = 1'b0;
        cmd_in    = 1'b1;
        start     = 1'b1;
        vec++;
        if ({done0, busy0, ok0} !== 3'b101) begin
            bad++;
            $display("FAIL b2b_first: done/busy/ok got %b expected 101", {done0, busy0, ok0});
        end
        @(negedge clk);
        start = 1'b0;
        vec++;
        if ({done0, busy0, ok0} !== 3'b010) begin
            bad++;
            $display("FAIL b2b_rearm: done/busy/ok got %b expected 010", {done0, busy0, ok0});
        end
        strobe(1'b1);
        send_bits(48'h48_00_00_01_AA_87, 47, 0);
        vec++;
        if ({done0, res0} !== {1'b1, pack(6'h08, 32'h1AA, 1, 0, 0)}) begin
            bad++;
            $display("FAIL b2b_second: done %b res %h expected 1 %h",
                     done0, res0, pack(6'h08, 32'h1AA, 1, 0, 0));
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_timeout();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
